// File: rtl/ppu_pkg.sv
`timescale 1ns/1ps
// ppu_pkg
//   Shared definitions for the PPU palette port: CPU register selects,
//   the palette page number, the PPUADDR write-latch state type and the
//   palette mirroring function used by both the storage and the control
//   logic.
package ppu_pkg;

  // CPU register selects (low three bits of the $2000-$2007 window)
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  // Upper six address bits that select palette space ($3F00-$3FFF)
  localparam logic [5:0] PAL_PAGE = 6'h3F;

  // Grayscale keeps only the luma row of the colour index
  localparam logic [5:0] GRAY_MASK = 6'h30;

  // A palette read still refills the read buffer from the nametable
  // underneath the palette page
  localparam logic [13:0] PAL_SHADOW_MASK = 14'h2FFF;

  localparam int PAL_ENTRIES = 32;

  // PPUADDR write latch: first write is the high byte, second the low byte
  typedef enum logic {
    W_FIRST  = 1'b0,
    W_SECOND = 1'b1
  } addr_latch_t;

  // Palette mirroring: entries whose colour field is 0 in the sprite half
  // ($10/$14/$18/$1C) alias the matching background entries.
  function automatic logic [4:0] mir(input logic [4:0] idx);
    logic [4:0] res;
    res = idx;
    if (idx[1:0] == 2'b00) begin
      res[4] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ppu_palette_mem.sv
`timescale 1ns/1ps
// ppu_palette_mem
//   32 x 6-bit palette storage held in flops. One write port and two
//   asynchronous read ports (render and CPU). Mirroring is applied to every
//   port internally, so callers pass raw 5-bit palette indices.
//   A write and a read of the same entry in the same cycle return the old
//   value, because reads see the current flop contents and the write lands
//   at the clock edge.
//
// Ports
//   CLK       clock
//   RST       synchronous active-high reset; all entries -> PAL_RESET_VAL
//   wr_en     write enable
//   wr_idx    raw write index
//   wr_data   6-bit write data
//   rnd_idx   raw render read index
//   rnd_data  render read data
//   cpu_idx   raw CPU read index
//   cpu_data  CPU read data
module ppu_palette_mem
  import ppu_pkg::*;
#(
  parameter logic [5:0] PAL_RESET_VAL = 6'h0F
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [4:0] wr_idx,
  input  logic [5:0] wr_data,
  input  logic [4:0] rnd_idx,
  output logic [5:0] rnd_data,
  input  logic [4:0] cpu_idx,
  output logic [5:0] cpu_data
);

  logic [PAL_ENTRIES-1:0][5:0] pal_q;
  logic [PAL_ENTRIES-1:0][5:0] pal_d;
  logic [4:0]                  wr_slot;

  assign wr_slot = mir(wr_idx);

  always_comb begin
    pal_d = pal_q;
    if (wr_en) begin
      pal_d[wr_slot] = wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= PAL_RESET_VAL;
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  assign rnd_data = pal_q[mir(rnd_idx)];
  assign cpu_data = pal_q[mir(cpu_idx)];

endmodule

// File: rtl/ppu_palette_port.sv
`timescale 1ns/1ps
// ppu_palette_port
//   Palette RAM owner and CPU PPUADDR/PPUDATA path. Converts each rendered
//   pixel into a 6-bit NES colour index one cycle later, and forwards CPU
//   data accesses below $3F00 to VRAM as one-cycle request pulses.
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   cpu_sel/a/rw     one-cycle CPU register strobe, select, read(1)/write(0)
//   cpu_wdata        CPU write data
//   cpu_rdata        PPUDATA read result, valid the cycle after the read
//   incr32           address step of 32 instead of 1 after a data access
//   grayscale        mask colour output to its luma row
//   pix_valid        pixel strobe; pix_sprite/pix_pal/pix_color describe it
//   force_backdrop   force palette entry 0
//   color_valid      registered pix_valid
//   color            registered colour index (holds when pix_valid = 0)
//   vram_req/we      one-cycle VRAM request and its direction
//   vram_addr/wdata  request address (pre-increment) and write data
//   vram_rvalid      VRAM read-data strobe; vram_rdata the data
module ppu_palette_port
  import ppu_pkg::*;
#(
  parameter logic [5:0] PAL_RESET_VAL = 6'h0F
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_sel,
  input  logic [2:0]  cpu_a,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        incr32,
  input  logic        grayscale,
  input  logic        pix_valid,
  input  logic        pix_sprite,
  input  logic [1:0]  pix_pal,
  input  logic [1:0]  pix_color,
  input  logic        force_backdrop,
  output logic        color_valid,
  output logic [5:0]  color,
  output logic        vram_req,
  output logic        vram_we,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  input  logic        vram_rvalid,
  input  logic [7:0]  vram_rdata
);

  // Outstanding VRAM reads. Responses are only accepted while a read is in
  // flight, so a response to a request issued before reset is dropped.
  localparam int PEND_W = 3;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  addr_latch_t       w_q, w_d;
  logic [13:0]       addr_q, addr_d;
  logic [7:0]        rbuf_q, rbuf_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              color_valid_q, color_valid_d;
  logic [5:0]        color_q, color_d;
  logic              vram_req_q, vram_req_d;
  logic              vram_we_q, vram_we_d;
  logic [13:0]       vram_addr_q, vram_addr_d;
  logic [7:0]        vram_wdata_q, vram_wdata_d;

  // ---------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------
  logic        sel_status_rd;
  logic        sel_addr_wr;
  logic        sel_data_wr;
  logic        sel_data_rd;
  logic        in_pal;
  logic        pal_we;
  logic        rbuf_load;
  logic [13:0] addr_step;
  logic [4:0]  rnd_idx;
  logic [5:0]  rnd_c;
  logic [5:0]  cpu_c;

  assign sel_status_rd = cpu_sel && (cpu_a == REG_STATUS) &&  cpu_rw;
  assign sel_addr_wr   = cpu_sel && (cpu_a == REG_ADDR)   && !cpu_rw;
  assign sel_data_wr   = cpu_sel && (cpu_a == REG_DATA)   && !cpu_rw;
  assign sel_data_rd   = cpu_sel && (cpu_a == REG_DATA)   &&  cpu_rw;

  assign in_pal    = (addr_q[13:8] == PAL_PAGE);
  assign pal_we    = sel_data_wr && in_pal;
  assign addr_step = incr32 ? 14'd32 : 14'd1;
  assign rbuf_load = vram_rvalid && (pend_q != '0);

  // Transparent pixels and forced border both resolve to the backdrop
  assign rnd_idx = (force_backdrop || (pix_color == 2'b00)) ? 5'd0
                 : {pix_sprite, pix_pal, pix_color};

  // ---------------------------------------------------------------------
  // Palette storage
  // ---------------------------------------------------------------------
  ppu_palette_mem #(
    .PAL_RESET_VAL(PAL_RESET_VAL)
  ) u_mem (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (pal_we),
    .wr_idx   (addr_q[4:0]),
    .wr_data  (cpu_wdata[5:0]),
    .rnd_idx  (rnd_idx),
    .rnd_data (rnd_c),
    .cpu_idx  (addr_q[4:0]),
    .cpu_data (cpu_c)
  );

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_d           = w_q;
    addr_d        = addr_q;
    rbuf_d        = rbuf_q;
    pend_d        = pend_q;
    cpu_rdata_d   = cpu_rdata_q;
    color_valid_d = pix_valid;
    color_d       = color_q;
    vram_req_d    = 1'b0;
    vram_we_d     = vram_we_q;
    vram_addr_d   = vram_addr_q;
    vram_wdata_d  = vram_wdata_q;

    // PPUADDR write latch
    if (sel_addr_wr) begin
      unique case (w_q)
        W_FIRST: begin
          addr_d = {cpu_wdata[5:0], addr_q[7:0]};
          w_d    = W_SECOND;
        end
        W_SECOND: begin
          addr_d = {addr_q[13:8], cpu_wdata};
          w_d    = W_FIRST;
        end
        default: w_d = W_FIRST;
      endcase
    end

    if (sel_status_rd) begin
      w_d = W_FIRST;
    end

    // PPUDATA access: VRAM request uses the pre-increment address
    if (sel_data_wr && !in_pal) begin
      vram_req_d   = 1'b1;
      vram_we_d    = 1'b1;
      vram_addr_d  = addr_q;
      vram_wdata_d = cpu_wdata;
    end

    if (sel_data_rd) begin
      // Palette reads bypass the buffer; the buffer is still refilled from
      // the nametable mirrored beneath the palette page.
      cpu_rdata_d = in_pal ? {2'b00, cpu_c} : rbuf_q;
      vram_req_d  = 1'b1;
      vram_we_d   = 1'b0;
      vram_addr_d = in_pal ? (addr_q & PAL_SHADOW_MASK) : addr_q;
    end

    if (sel_data_wr || sel_data_rd) begin
      addr_d = addr_q + addr_step;
    end

    // Read buffer: cpu_rdata above already took the old contents
    if (rbuf_load) begin
      rbuf_d = vram_rdata;
    end

    unique case ({sel_data_rd, rbuf_load})
      2'b10: if (pend_q != '1) pend_d = pend_q + 1'b1;
      2'b01: pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase

    // Render path
    if (pix_valid) begin
      color_d = grayscale ? (rnd_c & GRAY_MASK) : rnd_c;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_q           <= W_FIRST;
      addr_q        <= '0;
      rbuf_q        <= '0;
      pend_q        <= '0;
      cpu_rdata_q   <= '0;
      color_valid_q <= 1'b0;
      color_q       <= '0;
      vram_req_q    <= 1'b0;
      vram_we_q     <= 1'b0;
      vram_addr_q   <= '0;
      vram_wdata_q  <= '0;
    end else begin
      w_q           <= w_d;
      addr_q        <= addr_d;
      rbuf_q        <= rbuf_d;
      pend_q        <= pend_d;
      cpu_rdata_q   <= cpu_rdata_d;
      color_valid_q <= color_valid_d;
      color_q       <= color_d;
      vram_req_q    <= vram_req_d;
      vram_we_q     <= vram_we_d;
      vram_addr_q   <= vram_addr_d;
      vram_wdata_q  <= vram_wdata_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign color_valid = color_valid_q;
  assign color       = color_q;
  assign vram_req    = vram_req_q;
  assign vram_we     = vram_we_q;
  assign vram_addr   = vram_addr_q;
  assign vram_wdata  = vram_wdata_q;

endmodule

// File: tb/tb_ppu_palette_port.sv
`timescale 1ns/1ps
// Scoreboard bench for ppu_palette_port. The driver keeps a behavioural
// model (palette array, address, latch, read buffer, VRAM contents) and
// pushes expected responses; the monitor pops and compares whenever the
// DUT presents an output.
module tb_ppu_palette_port;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_sel;
  logic [2:0]  cpu_a;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        incr32;
  logic        grayscale;
  logic        pix_valid;
  logic        pix_sprite;
  logic [1:0]  pix_pal;
  logic [1:0]  pix_color;
  logic        force_backdrop;
  logic        color_valid;
  logic [5:0]  color;
  logic        vram_req;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_rvalid;
  logic [7:0]  vram_rdata;

  always #5 CLK = ~CLK;

  ppu_palette_port #(.PAL_RESET_VAL(6'h0F)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_sel(cpu_sel), .cpu_a(cpu_a), .cpu_rw(cpu_rw),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .incr32(incr32), .grayscale(grayscale),
    .pix_valid(pix_valid), .pix_sprite(pix_sprite), .pix_pal(pix_pal),
    .pix_color(pix_color), .force_backdrop(force_backdrop),
    .color_valid(color_valid), .color(color),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } vreq_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } resp_t;

  logic [5:0] exp_color_q[$];
  logic [7:0] exp_rdata_q[$];
  vreq_t      exp_vram_q[$];
  resp_t      resp_q[$];

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  // Behavioural model
  int         m_w;
  int         m_addr;
  int         m_rbuf;
  int         m_pal [32];
  logic [7:0] vmem [16384];
  int         cyc = 0;
  int         last_due = 0;
  bit         inj_pending = 0;
  logic [7:0] inj_data = 8'h00;

  // Sprite-half entries with colour 0 fold onto the background half
  function automatic int mmir(input int i);
    return (i % 4 == 0) ? (i % 16) : i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=output_present required=no_output", name);
  endtask

  // ---------------------------------------------------------------------
  // Driver: one call = one clock cycle of stimulus plus model update
  // ---------------------------------------------------------------------
  task automatic step(input logic sel, input logic [2:0] a, input logic rw,
                      input logic [7:0] wd);
    int idx;
    int c;
    int raddr;
    int due;
    resp_t r;
    cpu_sel   = sel;
    cpu_a     = a;
    cpu_rw    = rw;
    cpu_wdata = wd;

    // Pixel sees the palette before any same-cycle CPU write
    if (pix_valid) begin
      if (force_backdrop || pix_color == 2'd0) idx = 0;
      else idx = int'(pix_sprite) * 16 + int'(pix_pal) * 4 + int'(pix_color);
      c = m_pal[mmir(idx)];
      if (grayscale) c = (c / 16) * 16;
      exp_color_q.push_back(6'(c));
    end

    if (sel) begin
      if (a == 3'd6 && !rw) begin
        if (m_w == 0) begin
          m_addr = int'(wd % 64) * 256 + (m_addr % 256);
          m_w = 1;
        end else begin
          m_addr = (m_addr / 256) * 256 + int'(wd);
          m_w = 0;
        end
      end else if (a == 3'd2 && rw) begin
        m_w = 0;
      end else if (a == 3'd7) begin
        if (!rw) begin
          if (m_addr / 256 == 63) begin
            m_pal[mmir(m_addr % 32)] = int'(wd % 64);
          end else begin
            exp_vram_q.push_back(vreq_t'{we: 1'b1, addr: 14'(m_addr), wdata: wd});
            vmem[m_addr] = wd;
          end
        end else begin
          if (m_addr / 256 == 63) begin
            exp_rdata_q.push_back(8'(m_pal[mmir(m_addr % 32)]));
            raddr = m_addr - 16'h1000;   // $3Fxx reads refill from $2Fxx
          end else begin
            exp_rdata_q.push_back(8'(m_rbuf));
            raddr = m_addr;
          end
          exp_vram_q.push_back(vreq_t'{we: 1'b0, addr: 14'(raddr), wdata: 8'h00});
          due = cyc + int'($urandom_range(2, 5));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          r.due = due;
          r.data = vmem[raddr];
          resp_q.push_back(r);
        end
        m_addr = (m_addr + (incr32 ? 32 : 1)) % 16384;
      end
    end

    // VRAM responder; read data of a same-cycle register-7 read is the old buffer
    vram_rvalid = 1'b0;
    vram_rdata  = 8'h00;
    if (inj_pending) begin
      vram_rvalid = 1'b1;
      vram_rdata  = inj_data;
      inj_pending = 0;
    end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      vram_rvalid = 1'b1;
      vram_rdata  = resp_q[0].data;
      m_rbuf = int'(resp_q[0].data);
      void'(resp_q.pop_front());
    end

    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 8'h00);
  endtask

  task automatic set_pix(input logic v, input logic s, input logic [1:0] p,
                         input logic [1:0] c, input logic fb);
    pix_valid = v; pix_sprite = s; pix_pal = p; pix_color = c; force_backdrop = fb;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cpu_sel = 1'b0;
    pix_valid = 1'b0;
    vram_rvalid = 1'b0;
    m_w = 0; m_addr = 0; m_rbuf = 0;
    for (int i = 0; i < 32; i++) m_pal[i] = 15;
    resp_q.delete();
    last_due = 0;
    @(posedge CLK);
    #1;
    cyc++;
    RST = 1'b0;
  endtask

  initial begin
    int r;
    logic [2:0] bog_a;
    RST = 1'b1; cpu_sel = 0; cpu_a = 0; cpu_rw = 0; cpu_wdata = 0;
    incr32 = 0; grayscale = 0; vram_rvalid = 0; vram_rdata = 0;
    set_pix(0, 0, 0, 0, 0);
    for (int i = 0; i < 16384; i++) vmem[i] = 8'($urandom);
    @(posedge CLK); #1;
    do_reset();

    // Backdrop after reset
    set_pix(1, 0, 2'd1, 2'd0, 0); step(0, 0, 0, 0);
    set_pix(0, 0, 0, 0, 0);

    // Sprite entry $3F11
    step(1, 3'd6, 0, 8'h3F); step(1, 3'd6, 0, 8'h11); step(1, 3'd7, 0, 8'h2A);
    set_pix(1, 1, 2'd0, 2'd1, 0); step(1, 3'd7, 1, 8'h00);   // read $3F12
    set_pix(0, 0, 0, 0, 0); idle(1);

    // Mirror write $3F10 -> backdrop, then grayscale
    step(1, 3'd6, 0, 8'h3F); step(1, 3'd6, 0, 8'h10); step(1, 3'd7, 0, 8'h05);
    set_pix(1, 0, 2'd2, 2'd0, 0); step(0, 0, 0, 0);
    set_pix(1, 1, 2'd3, 2'd2, 1); grayscale = 1; step(0, 0, 0, 0);
    grayscale = 0; set_pix(0, 0, 0, 0, 0); idle(2);

    // incr32 VRAM writes
    incr32 = 1;
    step(1, 3'd6, 0, 8'h20); step(1, 3'd6, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 3'd7, 0, 8'($urandom));
    incr32 = 0; idle(2);

    // Buffered read, then wrap at $3FFF
    do_reset();
    vmem[14'h2400] = 8'h77;
    step(1, 3'd6, 0, 8'h24); step(1, 3'd6, 0, 8'h00);
    step(1, 3'd7, 1, 8'h00); idle(8);
    step(1, 3'd7, 1, 8'h00); idle(8);
    step(1, 3'd6, 0, 8'h3F); step(1, 3'd6, 0, 8'hFF);
    step(1, 3'd7, 1, 8'h00); step(1, 3'd7, 0, 8'h5A); idle(8);

    // Status read clears the latch
    step(1, 3'd6, 0, 8'h13); step(1, 3'd2, 1, 8'h00);
    step(1, 3'd6, 0, 8'h21); step(1, 3'd6, 0, 8'h08); step(1, 3'd7, 0, 8'hC3);
    idle(2);

    // Reset between PPUADDR writes
    step(1, 3'd6, 0, 8'h23);
    do_reset();
    step(1, 3'd7, 0, 8'hAB);
    step(1, 3'd6, 0, 8'h24); step(1, 3'd6, 0, 8'h10); step(1, 3'd7, 0, 8'hCD);
    idle(2);

    // Response to a pre-reset read is ignored
    step(1, 3'd6, 0, 8'h25); step(1, 3'd6, 0, 8'h00); step(1, 3'd7, 1, 8'h00);
    do_reset();
    inj_pending = 1; inj_data = 8'h99; idle(1);
    step(1, 3'd6, 0, 8'h25); step(1, 3'd6, 0, 8'h00); step(1, 3'd7, 1, 8'h00);
    idle(8);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      set_pix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0));
      grayscale = ($urandom_range(0, 7) == 0);
      incr32 = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 10));
      case (r)
        0, 1: step(1, 3'd6, 0, $urandom_range(0, 1) ? 8'h3F : 8'($urandom));
        2: step(1, 3'd2, 1, 8'h00);
        3, 4: step(1, 3'd7, 0, 8'($urandom));
        5, 6: step(1, 3'd7, 1, 8'h00);
        7: begin
          bog_a = 3'($urandom_range(0, 4));
          if (bog_a >= 3'd2) bog_a = bog_a + 3'd1;
          step(1, bog_a, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        8: begin
          if ($urandom_range(0, 1) == 1) step(1, 3'd6, 1, 8'($urandom));
          else step(1, 3'd2, 0, 8'($urandom));
        end
        9: if ($urandom_range(0, 40) == 0) do_reset(); else step(0, 0, 0, 0);
        default: step(0, 0, 0, 0);
      endcase
    end
    set_pix(0, 0, 0, 0, 0);
    idle(10);
    done = 1;
  end

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  initial begin
    logic       rst_seen;
    logic       rd_seen;
    logic [5:0] hold;
    vreq_t      e;
    hold = 6'h00;
    forever begin
      @(posedge CLK);
      rst_seen = RST;
      rd_seen  = cpu_sel && (cpu_a == 3'd7) && cpu_rw && !RST;
      @(negedge CLK);
      if (rst_seen) begin
        chk("reset_cpu_rdata", cpu_rdata, 0);
        chk("reset_color", color, 0);
        chk("reset_color_valid", color_valid, 0);
        chk("reset_vram_req", vram_req, 0);
        chk("reset_vram_we", vram_we, 0);
        chk("reset_vram_addr", vram_addr, 0);
        chk("reset_vram_wdata", vram_wdata, 0);
        hold = 6'h00;
      end else begin
        if (color_valid) begin
          if (exp_color_q.size() == 0) unexpected("color_extra");
          else begin
            hold = exp_color_q.pop_front();
            chk("color", color, hold);
          end
        end else begin
          chk("color_hold", color, hold);
        end
        if (vram_req) begin
          if (exp_vram_q.size() == 0) unexpected("vram_req_extra");
          else begin
            e = exp_vram_q.pop_front();
            chk("vram_we", vram_we, e.we);
            chk("vram_addr", vram_addr, e.addr);
            if (e.we) chk("vram_wdata", vram_wdata, e.wdata);
          end
        end
        if (rd_seen) begin
          if (exp_rdata_q.size() == 0) unexpected("cpu_rdata_extra");
          else chk("cpu_rdata", cpu_rdata, exp_rdata_q.pop_front());
        end
      end
      if (done) begin
        chk("color_queue_drained", exp_color_q.size(), 0);
        chk("vram_queue_drained", exp_vram_q.size(), 0);
        chk("rdata_queue_drained", exp_rdata_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ppu_palette_port.md
# ppu_palette_port

Upstream neighbour of the composite encoder. Owns the 32-entry palette RAM and the CPU-side PPUADDR/PPUDATA ($2006/$2007) path. Each cycle it converts a rendered pixel (background/sprite, 2-bit palette, 2-bit colour) into the 6-bit NES colour index that the encoder turns into hue and luma. CPU $2007 accesses to addresses below $3F00 go out on a simple VRAM request port.

## Interface
Parameters:
- PAL_RESET_VAL, 6'h0F: value loaded into every palette entry on reset.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- cpu_sel  in  1  one-cycle strobe that marks a CPU register access.
- cpu_a  in  3  register select (2 = PPUSTATUS, 6 = PPUADDR, 7 = PPUDATA).
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  PPUDATA read result; valid the cycle after a read of register 7.
- incr32  in  1  PPUCTRL bit 2; selects an address step of 32 instead of 1.
- grayscale  in  1  PPUMASK bit 0.
- pix_valid  in  1  pixel strobe from the render pipeline.
- pix_sprite  in  1  1 = sprite pixel, 0 = background pixel.
- pix_pal  in  2  palette number.
- pix_color  in  2  colour within the palette; 0 = transparent.
- force_backdrop  in  1  forces palette entry 0 (border and blanking).
- color_valid  out  1  registered copy of pix_valid.
- color  out  6  NES colour index sent to the encoder.
- vram_req  out  1  one-cycle VRAM request pulse.
- vram_we  out  1  1 = write request.
- vram_addr  out  14  VRAM address for the request.
- vram_wdata  out  8  VRAM write data.
- vram_rvalid  in  1  read-data strobe returned by VRAM.
- vram_rdata  in  8  read data returned by VRAM.

## Operation
- State:
  - toggle w (1b), the PPUADDR write latch.
  - addr (14b).
  - rbuf (8b), the PPUDATA read buffer.
  - pal[0:31] (6b each).
- Write to register 6:
  - When w = 0: addr[13:8] <= wdata[5:0], w <= 1.
  - When w = 1: addr[7:0] <= wdata, w <= 0.
- Read of register 2: w <= 0. This block drives no data for register 2.
- Write to register 7:
  - When addr[13:8] = 6'h3F: pal[mir(addr[4:0])] <= wdata[5:0].
  - Otherwise: vram_req = 1, vram_we = 1, vram_addr = addr, vram_wdata = wdata.
- Read of register 7:
  - When addr[13:8] = 6'h3F: cpu_rdata <= {2'b00, pal[mir]}. A VRAM read of addr & 14'h2FFF is also issued to refill rbuf, matching hardware.
  - Otherwise: cpu_rdata <= rbuf, and a VRAM read of addr is issued (vram_req = 1, vram_we = 0).
- After every register-7 access, addr <= addr + (incr32 ? 32 : 1), wrapping modulo 2^14.
- rbuf <= vram_rdata on any cycle where vram_rvalid = 1.
- Mirroring mir(i): when i[1:0] = 0, clear i[4]. So $3F10/14/18/1C alias $3F00/04/08/0C.
- Render lookup:
  - idx = (force_backdrop | pix_color == 0) ? 0 : {pix_sprite, pix_pal, pix_color}.
  - c = pal[mir(idx)].
  - color <= grayscale ? (c & 6'h30) : c.
- cpu_sel with cpu_a outside {2, 6, 7} is ignored.

## Timing
- Render path: exactly 1-cycle latency. color and color_valid are registered; color holds its value when pix_valid = 0.
- A CPU palette write and a render read of the same entry in the same cycle: the render output gets the old value (read before write).
- A CPU access takes effect at the end of the strobe cycle. Back-to-back strobes on consecutive cycles are legal.
- vram_req is asserted the cycle after the strobe, for exactly one cycle. vram_addr carries the pre-increment addr.
- vram_rvalid may arrive any number of cycles later. If a second read is issued before it arrives, cpu_rdata still returns the current rbuf.
- vram_rvalid coinciding with a register-7 read: cpu_rdata returns the old rbuf, and rbuf takes the new data.
- Reset values:
  - Outputs: cpu_rdata = 0, color = 0, color_valid = 0, vram_req = 0, vram_we = 0, vram_addr = 0, vram_wdata = 0.
  - State: w = 0, addr = 0, rbuf = 0, every pal entry = PAL_RESET_VAL.
- A reset asserted mid-sequence (e.g. between the two PPUADDR writes) discards the partial address. A VRAM response arriving after reset is ignored.

## Structure
- Package ppu_pkg, holding:
  - Register-select constants REG_STATUS = 2, REG_ADDR = 6, REG_DATA = 7.
  - PAL_PAGE = 6'h3F.
  - The mir() function.
- Sub-module ppu_palette_mem:
  - Storage: 32 × 6 flops, reset to PAL_RESET_VAL.
  - Ports: one write port and two read ports (render and CPU), all with mirroring applied internally.
- Top-level logic: latch/address FSM, read buffer and VRAM request logic.

## Test plan
- Reset, then render pix_color = 0 with no writes -> color = 6'h0F one cycle later, color_valid = 1.
- Write $3F to reg 6, $11 to reg 6, $2A to reg 7 -> pal[17] = $2A; pixel sprite = 1, pal = 0, color = 1 -> color = $2A; addr = $3F12.
- Write $3F10 via reg 6 and data $05 via reg 7 -> background backdrop pixel gives color = $05. Then set grayscale = 1 -> color = $00.
- incr32 = 1, addr = $2000, three register-7 writes -> vram_addr sequence $2000, $2020, $2040; vram_we = 1 on each.
- addr = $2400; first reg-7 read returns rbuf = $00, VRAM responds $77; second read returns $77. A read at addr = $3FFF wraps addr to $0000.
- One reg-6 write, then a reg-2 read, then two reg-6 writes $21 and $08 -> addr = $2108. Asserting RST between two reg-6 writes -> w = 0 and addr = 0.
